// File: rtl/adc9653_pkg.sv
// Shared definitions for the AD9653 link-training sequencer.
// Holds the FSM state type, default training constants and the 16-bit
// rotate helper used by the pattern checker.
package adc9653_pkg;

  localparam int unsigned  NUM_CH_DEF     = 4;
  localparam int unsigned  WORD_W         = 16;
  localparam int unsigned  TAP_W_DEF      = 5;
  localparam logic [15:0]  PATTERN_DEF    = 16'hA1B2;
  localparam int unsigned  SETTLE_CYC_DEF = 16;
  localparam int unsigned  CHK_CYC_DEF    = 64;
  localparam int unsigned  MIN_EYE_DEF    = 4;
  localparam int unsigned  MAX_SLIP_DEF   = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_TAP,
    ST_SETTLE,
    ST_CHECK,
    ST_NEXT,
    ST_CENTER,
    ST_C_SETTLE,
    ST_ALIGN_CHK,
    ST_SLIP,
    ST_S_SETTLE,
    ST_DONE,
    ST_FAIL
  } state_e;

  // Rotate a 16-bit word left by k bit positions.
  function automatic logic [15:0] rotl16(input logic [15:0] w, input logic [3:0] k);
    logic [31:0] dbl;
    dbl = {w, w} << k;
    return dbl[31:16];
  endfunction

endpackage

// File: rtl/adc9653_pat_chk.sv
// Per-sample training-pattern compare across all channel words.
// Ports:
//   din      in  NUM_CH x 16 parallel capture data (ch0 = din[15:0])
//   rot_ok   out every channel word is some rotation of PATTERN (comb)
//   exact_ok out every channel word equals PATTERN exactly (comb)
module adc9653_pat_chk
  import adc9653_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter logic [15:0] PATTERN = PATTERN_DEF
) (
  input  logic [NUM_CH*WORD_W-1:0] din,
  output logic                     rot_ok,
  output logic                     exact_ok
);

  // Each channel may sit at its own rotation during the tap sweep.
  always_comb begin
    logic hit;
    rot_ok   = 1'b1;
    exact_ok = 1'b1;
    hit      = 1'b0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      hit = 1'b0;
      for (int unsigned k = 0; k < WORD_W; k++) begin
        if (din[ch*WORD_W +: WORD_W] == rotl16(PATTERN, 4'(k))) hit = 1'b1;
      end
      if (!hit) rot_ok = 1'b0;
      if (din[ch*WORD_W +: WORD_W] != PATTERN) exact_ok = 1'b0;
    end
  end

endmodule

// File: rtl/adc9653_align_ctrl.sv
// AD9653 LVDS link-training sequencer: sweeps the shared IDELAY tap, picks
// the widest (earliest on ties) passing eye, loads its centre tap, then
// bitslips until every channel word equals the training pattern.
// Ports:
//   clk_adc, rst        clock and synchronous active-high reset
//   start               one-cycle pulse, starts training when not busy
//   din                 NUM_CH x 16 parallel capture data
//   tap_ld, tap_val     tap load pulse and held tap value
//   bitslip             one-cycle bitslip pulse to all lanes
//   busy, done, fail    status levels
//   eye_start, eye_len  chosen eye
//   tap_map             per-tap pass bitmap (only with ADC_ALIGN_DBG_EN)
module adc9653_align_ctrl
  import adc9653_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned TAP_W      = TAP_W_DEF,
  parameter logic [15:0] PATTERN    = PATTERN_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned CHK_CYC    = CHK_CYC_DEF,
  parameter int unsigned MIN_EYE    = MIN_EYE_DEF,
  parameter int unsigned MAX_SLIP   = MAX_SLIP_DEF
) (
  input  logic                     clk_adc,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*WORD_W-1:0] din,
  output logic                     tap_ld,
  output logic [TAP_W-1:0]         tap_val,
  output logic                     bitslip,
  output logic                     busy,
  output logic                     done,
  output logic                     fail,
  output logic [TAP_W-1:0]         eye_start,
  output logic [TAP_W:0]           eye_len
`ifdef ADC_ALIGN_DBG_EN
  ,
  output logic [(1<<TAP_W)-1:0]    tap_map
`endif
);

  localparam int unsigned LEN_W   = TAP_W + 1;
  localparam int unsigned CNT_MAX = (CHK_CYC > SETTLE_CYC) ? CHK_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned SLIP_W  = $clog2(MAX_SLIP + 1) + 1;

  state_e             state_q, state_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pass_q, pass_d;
  logic [LEN_W-1:0]   cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic [TAP_W-1:0]   cur_start_q, cur_start_d, best_start_q, best_start_d;
  logic [SLIP_W-1:0]  slips_q, slips_d;
  logic               tap_ld_q, tap_ld_d, bitslip_q, bitslip_d;
  logic [TAP_W-1:0]   tap_val_q, tap_val_d, eye_start_q, eye_start_d;
  logic [LEN_W-1:0]   eye_len_q, eye_len_d;
  logic               busy_q, busy_d, done_q, done_d, fail_q, fail_d;
`ifdef ADC_ALIGN_DBG_EN
  logic [(1<<TAP_W)-1:0] tap_map_q, tap_map_d;
`endif

  logic               rot_ok, exact_ok;
  logic [LEN_W-1:0]   run_len_c;
  logic [TAP_W-1:0]   run_start_c, center_c;

  adc9653_pat_chk #(.NUM_CH(NUM_CH), .PATTERN(PATTERN)) u_pat_chk (
    .din      (din),
    .rot_ok   (rot_ok),
    .exact_ok (exact_ok)
  );

  // Run tracker candidates and centre of the best eye.
  assign run_len_c   = cur_len_q + LEN_W'(1);
  assign run_start_c = (cur_len_q == '0) ? tap_q : cur_start_q;
  assign center_c    = TAP_W'(LEN_W'(best_start_q) + (best_len_q >> 1));

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      cnt_q        <= '0;
      pass_q       <= 1'b0;
      cur_len_q    <= '0;
      cur_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      slips_q      <= '0;
      tap_ld_q     <= 1'b0;
      tap_val_q    <= '0;
      bitslip_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      eye_start_q  <= '0;
      eye_len_q    <= '0;
`ifdef ADC_ALIGN_DBG_EN
      tap_map_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      cur_len_q    <= cur_len_d;
      cur_start_q  <= cur_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      slips_q      <= slips_d;
      tap_ld_q     <= tap_ld_d;
      tap_val_q    <= tap_val_d;
      bitslip_q    <= bitslip_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      eye_start_q  <= eye_start_d;
      eye_len_q    <= eye_len_d;
`ifdef ADC_ALIGN_DBG_EN
      tap_map_q    <= tap_map_d;
`endif
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    cur_len_d    = cur_len_q;
    cur_start_d  = cur_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    slips_d      = slips_q;
    tap_ld_d     = 1'b0;
    tap_val_d    = tap_val_q;
    bitslip_d    = 1'b0;
    eye_start_d  = eye_start_q;
    eye_len_d    = eye_len_q;
`ifdef ADC_ALIGN_DBG_EN
    tap_map_d    = tap_map_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d      = ST_SET_TAP;
          tap_d        = '0;
          cur_len_d    = '0;
          cur_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
          slips_d      = '0;
          eye_start_d  = '0;
          eye_len_d    = '0;
`ifdef ADC_ALIGN_DBG_EN
          tap_map_d    = '0;
`endif
        end
      end
      ST_SET_TAP: begin
        tap_ld_d  = 1'b1;
        tap_val_d = tap_q;
        cnt_d     = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE, ST_C_SETTLE, ST_S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          pass_d  = 1'b1;
          state_d = (state_q == ST_SETTLE) ? ST_CHECK : ST_ALIGN_CHK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        pass_d = pass_q & rot_ok;
        if (cnt_q == CNT_W'(CHK_CYC - 1)) state_d = ST_NEXT;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_NEXT: begin
        if (pass_q) begin
          cur_len_d   = run_len_c;
          cur_start_d = run_start_c;
          // Strictly longer only, so the earliest eye wins a tie.
          if (run_len_c > best_len_q) begin
            best_len_d   = run_len_c;
            best_start_d = run_start_c;
          end
`ifdef ADC_ALIGN_DBG_EN
          tap_map_d[tap_q] = 1'b1;
`endif
        end else begin
          cur_len_d = '0;
        end
        if (tap_q == '1) begin
          state_d = ST_CENTER;
        end else begin
          tap_d   = tap_q + TAP_W'(1);
          state_d = ST_SET_TAP;
        end
      end
      ST_CENTER: begin
        tap_ld_d = 1'b1;
        if (best_len_q < LEN_W'(MIN_EYE)) begin
          tap_val_d = '0;
          state_d   = ST_FAIL;
        end else begin
          tap_val_d   = center_c;
          eye_start_d = best_start_q;
          eye_len_d   = best_len_q;
          cnt_d       = '0;
          state_d     = ST_C_SETTLE;
        end
      end
      ST_ALIGN_CHK: begin
        if (cnt_q == CNT_W'(CHK_CYC - 1)) begin
          if (pass_q & exact_ok) begin
            state_d = ST_DONE;
          end else if (slips_q < SLIP_W'(MAX_SLIP)) begin
            state_d = ST_SLIP;
          end else begin
            tap_ld_d  = 1'b1;
            tap_val_d = '0;
            state_d   = ST_FAIL;
          end
        end else begin
          pass_d = pass_q & exact_ok;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      ST_SLIP: begin
        bitslip_d = 1'b1;
        slips_d   = slips_q + SLIP_W'(1);
        cnt_d     = '0;
        state_d   = ST_S_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
    done_d = (state_d == ST_DONE);
    fail_d = (state_d == ST_FAIL);
  end

  assign tap_ld    = tap_ld_q;
  assign tap_val   = tap_val_q;
  assign bitslip   = bitslip_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign eye_start = eye_start_q;
  assign eye_len   = eye_len_q;
`ifdef ADC_ALIGN_DBG_EN
  assign tap_map   = tap_map_q;
`endif

endmodule

// File: tb/tb_adc9653_align_ctrl.sv
// Self-checking bench for adc9653_align_ctrl with a behavioural ADC model.
module tb_adc9653_align_ctrl;
  import adc9653_pkg::*;

  localparam int NTAP     = 32;
  localparam int SETTLE   = 16;
  localparam int CHK      = 64;
  localparam int MINEYE   = 4;
  localparam int MAXSLIP  = 8;
  localparam int WAIT_MAX = 8000;

  logic        clk_adc = 1'b0;
  logic        rst     = 1'b1;
  logic        start   = 1'b0;
  logic [63:0] din     = '0;
  logic        tap_ld, bitslip, busy, done, fail;
  logic [4:0]  tap_val, eye_start;
  logic [5:0]  eye_len;
`ifdef ADC_ALIGN_DBG_EN
  logic [31:0] tap_map;
`endif

  always #4 clk_adc = ~clk_adc;

  adc9653_align_ctrl dut (
    .clk_adc   (clk_adc),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .tap_ld    (tap_ld),
    .tap_val   (tap_val),
    .bitslip   (bitslip),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .eye_start (eye_start),
    .eye_len   (eye_len)
`ifdef ADC_ALIGN_DBG_EN
    ,
    .tap_map   (tap_map)
`endif
  );

  typedef struct {
    logic [31:0] map;
    int          mis;
    bit          skew;
    bit          exp_done;
    int          exp_start;
    int          exp_len;
    int          exp_center;
    int          exp_slips;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         ld_total = 0;
  int         slip_total = 0;
  logic [4:0] ld_log [1024];
  int         slip_cyc [256];
  logic [4:0] cur_tap = '0;
  int         ld_base = 0;
  int         slip_base = 0;
  logic [31:0] pass_map = '0;
  int          mis = 0;
  bit          skew = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rot_by(input logic [15:0] w, input int n);
    logic [15:0] r;
    r = w;
    repeat (n % 16) r = {r[14:0], r[15]};
    return r;
  endfunction

  function automatic bit is_rot(input logic [15:0] w);
    for (int k = 0; k < 16; k++) if (w == rot_by(PATTERN_DEF, k)) return 1'b1;
    return 1'b0;
  endfunction

  // ADC sample: good taps give rotated patterns, bad taps glitch one channel.
  function automatic logic [63:0] gen_sample();
    logic [63:0] d;
    logic [15:0] bad;
    int loads, sl, k;
    loads = ld_total - ld_base;
    sl    = slip_total - slip_base;
    for (int ch = 0; ch < 4; ch++) begin
      if (loads <= NTAP) k = int'($urandom_range(0, 15));
      else               k = mis + sl + ((skew && ch == 2) ? 1 : 0);
      d[ch*16 +: 16] = rot_by(PATTERN_DEF, k);
    end
    if (!pass_map[cur_tap] && $urandom_range(0, 3) == 0) begin
      bad = 16'($urandom);
      if (is_rot(bad)) bad = ~bad;
      d[$urandom_range(0, 3)*16 +: 16] = bad;
    end
    return d;
  endfunction

  always @(posedge clk_adc) begin
    cyc++;
    if (tap_ld) begin
      if (ld_total < 1024) ld_log[ld_total] = tap_val;
      ld_total++;
      cur_tap = tap_val;
    end
    if (bitslip) begin
      if (slip_total < 256) slip_cyc[slip_total] = cyc;
      slip_total++;
    end
    #1 din = gen_sample();
  end

  // Expected outcome from the passing-tap map and word misalignment.
  function automatic vec_t model(input logic [31:0] map, input int m, input bit sk);
    vec_t v;
    int bs, bl, len, need;
    v.map = map; v.mis = m; v.skew = sk;
    bs = 0; bl = 0;
    for (int s = 0; s < NTAP; s++) begin
      if (map[s] && (s == 0 || !map[s-1])) begin
        len = 0;
        while (s + len < NTAP && map[s+len]) len++;
        if (len > bl) begin bl = len; bs = s; end
      end
    end
    if (bl < MINEYE) begin
      v.exp_done = 1'b0; v.exp_start = 0; v.exp_len = 0; v.exp_center = 0; v.exp_slips = 0;
    end else begin
      v.exp_start = bs; v.exp_len = bl; v.exp_center = bs + bl / 2;
      need = sk ? 99 : (16 - m) % 16;
      v.exp_done  = (need <= MAXSLIP);
      v.exp_slips = v.exp_done ? need : MAXSLIP;
    end
    return v;
  endfunction

  task automatic run_case(input vec_t v, input string tag);
    int n, nld, exp_n, mism, gapbad, nsl;
    int exp_seq [34];
    pass_map = v.map; mis = v.mis; skew = v.skew;
    ld_base = ld_total; slip_base = slip_total;
    @(negedge clk_adc) start = 1'b1;
    @(negedge clk_adc) start = 1'b0;
    n = 0;
    while (!(done || fail) && n < WAIT_MAX) begin
      @(negedge clk_adc);
      n++;
      if (n == 500) begin
        start = 1'b1;
        @(negedge clk_adc) start = 1'b0;
        n++;
      end
    end
    chk({tag, " timeout"}, longint'(n >= WAIT_MAX), 0);
    repeat (2) @(negedge clk_adc);
    exp_n = 0;
    for (int t = 0; t < NTAP; t++) exp_seq[exp_n++] = t;
    if (v.exp_len >= MINEYE) exp_seq[exp_n++] = v.exp_center;
    if (!v.exp_done) exp_seq[exp_n++] = 0;
    nld = ld_total - ld_base;
    chk({tag, " tap_ld count"}, nld, exp_n);
    mism = 0;
    for (int i = 0; i < exp_n && i < nld; i++)
      if (int'(ld_log[ld_base + i]) != exp_seq[i]) mism++;
    chk({tag, " tap_ld sequence mismatches"}, mism, 0);
    chk({tag, " tap_val held"}, tap_val, exp_seq[exp_n-1]);
    chk({tag, " done"}, done, v.exp_done);
    chk({tag, " fail"}, fail, !v.exp_done);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " eye_start"}, eye_start, v.exp_start);
    chk({tag, " eye_len"}, eye_len, v.exp_len);
    nsl = slip_total - slip_base;
    chk({tag, " bitslip count"}, nsl, v.exp_slips);
    gapbad = 0;
    for (int i = 1; i < nsl; i++)
      if (slip_cyc[slip_base + i] - slip_cyc[slip_base + i - 1] < SETTLE + CHK) gapbad++;
    chk({tag, " bitslip spacing violations"}, gapbad, 0);
  endtask

  vec_t tbl [7];

  initial begin
    int n, ld_snap;
    vec_t rv;
    logic [31:0] m;
    int s, l;

    tbl[0] = '{32'h000FFC00, 0,  1'b0, 1'b1, 10, 10, 15, 0};
    tbl[1] = '{32'hFFFFFFFF, 0,  1'b0, 1'b1, 0,  32, 16, 0};
    tbl[2] = '{32'h01F000F8, 0,  1'b0, 1'b1, 3,  5,  5,  0};
    tbl[3] = '{32'h00000700, 0,  1'b0, 1'b0, 0,  0,  0,  0};
    tbl[4] = '{32'h000FFC00, 13, 1'b0, 1'b1, 10, 10, 15, 3};
    tbl[5] = '{32'h000FFC00, 0,  1'b1, 1'b0, 10, 10, 15, 8};
    tbl[6] = '{32'hFC000000, 8,  1'b0, 1'b1, 26, 6,  29, 8};

    repeat (3) @(negedge clk_adc);
    chk("reset status", {busy, done, fail, tap_ld, bitslip}, 0);
    chk("reset tap_val", tap_val, 0);
    chk("reset eye", {eye_start, eye_len}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_adc);

    for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 6; i++) begin
      s = int'($urandom_range(0, 28));
      l = int'($urandom_range(1, 32 - s));
      m = '0;
      for (int b = s; b < s + l; b++) m[b] = 1'b1;
      m = m | (32'($urandom) & 32'($urandom) & 32'($urandom));
      rv = model(m, int'($urandom_range(0, 15)), 1'b0);
      run_case(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of the sweep, while settling at tap 12.
    pass_map = '1; mis = 0; skew = 1'b0;
    ld_base = ld_total; slip_base = slip_total;
    @(negedge clk_adc) start = 1'b1;
    @(negedge clk_adc) start = 1'b0;
    n = 0;
    while (ld_total - ld_base < 13 && n < WAIT_MAX) begin @(negedge clk_adc); n++; end
    chk("mid-sweep reach tap 12", ld_log[ld_total - 1], 12);
    repeat (3) @(negedge clk_adc);
    rst = 1'b1;
    @(negedge clk_adc);
    chk("abort status", {busy, done, fail, tap_ld, bitslip}, 0);
    chk("abort tap_val", tap_val, 0);
    chk("abort eye", {eye_start, eye_len}, 0);
    rst = 1'b0;
    ld_snap = ld_total;
    repeat (300) @(negedge clk_adc);
    chk("no tap_ld after abort", ld_total - ld_snap, 0);
    chk("idle after abort", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
